// File: rtl/softmax_max_buffer.sv
// rtl/softmax_max_buffer.sv - buffers one vector of IEEE-754 elements, tracks its maximum, then replays it in order
module softmax_max_buffer #(
  parameter int DATA_SIZE = 32,
  parameter int NUM_DATA  = 10
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               start_i,
  input  logic                               data_valid_i,
  input  logic [DATA_SIZE-1:0]               data_i,
  output logic                               in_ready_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [DATA_SIZE-1:0]               out_data_o,
  output logic [DATA_SIZE-1:0]               out_max_o,
  output logic [$clog2(NUM_DATA)-1:0]        out_max_index_o,
  output logic                               out_last_o,
  output logic                               restart_o
);

  localparam int ADDR_SIZE = $clog2(NUM_DATA);
  localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(NUM_DATA - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   count_q, count_d;
  logic [ADDR_SIZE-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_SIZE-1:0]   max_q, max_d;
  logic [ADDR_SIZE-1:0]   max_index_q, max_index_d;
  logic                   out_valid_q, out_valid_d;
  logic                   restart_q, restart_d;

  logic [DATA_SIZE-1:0]   mem_q [NUM_DATA];
  logic                   wr_en;
  logic [ADDR_SIZE-1:0]   wr_addr;
  logic                   accept;

  // Sign-magnitude ordering: zeros of either sign compare equal, negatives order by reversed magnitude.
  function automatic logic is_greater(input logic [DATA_SIZE-1:0] a, input logic [DATA_SIZE-1:0] b);
    logic [DATA_SIZE-2:0] mag_a;
    logic [DATA_SIZE-2:0] mag_b;
    logic                 sgn_a;
    logic                 sgn_b;
    mag_a = a[DATA_SIZE-2:0];
    mag_b = b[DATA_SIZE-2:0];
    sgn_a = a[DATA_SIZE-1];
    sgn_b = b[DATA_SIZE-1];
    if ((mag_a == '0) && (mag_b == '0)) return 1'b0;
    if (sgn_a != sgn_b) return !sgn_a;
    if (!sgn_a) return mag_a > mag_b;
    return mag_a < mag_b;
  endfunction

  assign in_ready_o      = !reset_i && (state_q != DRAIN);
  assign accept          = data_valid_i && in_ready_o;
  assign out_valid_o     = out_valid_q;
  assign out_data_o      = out_valid_q ? mem_q[rd_ptr_q] : '0;
  assign out_max_o       = max_q;
  assign out_max_index_o = max_index_q;
  assign out_last_o      = out_valid_q && (rd_ptr_q == LAST_IDX);
  assign restart_o       = restart_q;

  // Next-state: load sequencing with running maximum, restart on a fresh start, drain on handshakes.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    max_d       = max_q;
    max_index_d = max_index_q;
    out_valid_d = out_valid_q;
    restart_d   = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    case (state_q)
      IDLE: begin
        if (accept && start_i) begin
          wr_en       = 1'b1;
          max_d       = data_i;
          max_index_d = '0;
          count_d     = ADDR_SIZE'(1);
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (accept && start_i) begin
          wr_en       = 1'b1;
          max_d       = data_i;
          max_index_d = '0;
          count_d     = ADDR_SIZE'(1);
          restart_d   = 1'b1;
        end else if (accept) begin
          wr_en   = 1'b1;
          wr_addr = count_q;
          if (is_greater(data_i, max_q)) begin
            max_d       = data_i;
            max_index_d = count_q;
          end
          if (count_q == LAST_IDX) begin
            state_d     = DRAIN;
            out_valid_d = 1'b1;
            count_d     = '0;
            rd_ptr_d    = '0;
          end else begin
            count_d = count_q + ADDR_SIZE'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready_i) begin
          if (rd_ptr_q == LAST_IDX) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            rd_ptr_d    = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_SIZE'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset discards any frame in progress.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      max_q       <= '0;
      max_index_q <= '0;
      out_valid_q <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      max_q       <= max_d;
      max_index_q <= max_index_d;
      out_valid_q <= out_valid_d;
      restart_q   <= restart_d;
    end
  end

  // Element storage; contents survive reset since every frame rewrites what it replays.
  always_ff @(posedge clock_i) begin
    if (wr_en) mem_q[wr_addr] <= data_i;
  end

endmodule

// File: tb/tb_softmax_max_buffer.sv
// tb/tb_softmax_max_buffer.sv - directed scoreboard bench for softmax_max_buffer
module tb_softmax_max_buffer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        data_valid_i;
  logic [31:0] data_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [31:0] out_max_o;
  logic [3:0]  out_max_index_o;
  logic        out_last_o;
  logic        restart_o;

  typedef struct {
    logic [31:0] data;
    logic [31:0] mx;
    logic [31:0] idx;
    logic        last;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] frm [10];
  int          vectors = 0;
  int          miscompares = 0;

  softmax_max_buffer #(.DATA_SIZE(32), .NUM_DATA(10)) dut (
    .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .data_valid_i(data_valid_i),
    .data_i(data_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_max_o(out_max_o),
    .out_max_index_o(out_max_index_o), .out_last_o(out_last_o), .restart_o(restart_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one element at a negedge; return at the negedge after it was sampled.
  task automatic send_word(input logic st, input logic [31:0] d);
    start_i      = st;
    data_valid_i = 1'b1;
    data_i       = d;
    @(negedge clk);
    data_valid_i = 1'b0;
    start_i      = 1'b0;
  endtask

  task automatic push_frame(input logic [31:0] emax, input logic [31:0] eidx);
    for (int i = 0; i < 10; i++) begin
      sb_t e;
      e.data = frm[i];
      e.mx   = emax;
      e.idx  = eidx;
      e.last = (i == 9);
      sb.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [31:0] emax, input logic [31:0] eidx);
    push_frame(emax, eidx);
    for (int i = 0; i < 10; i++) begin
      check("in_ready_load", in_ready_o, 1);
      send_word(i == 0, frm[i]);
    end
    check("valid_latency", out_valid_o, 1);
    check("in_ready_drain", in_ready_o, 0);
  endtask

  // Drain until the scoreboard empties; bp toggles out_ready_i and injects ignored inputs.
  task automatic drain(input bit bp, input int stop_at);
    int guard = 0;
    while (sb.size() > stop_at && guard < 100) begin
      check("drain_valid", out_valid_o, 1);
      check("drain_data", out_data_o, sb[0].data);
      check("drain_max", out_max_o, sb[0].mx);
      check("drain_idx", 32'(out_max_index_o), sb[0].idx);
      check("drain_last", out_last_o, sb[0].last);
      check("drain_in_ready", in_ready_o, 0);
      out_ready_i  = bp ? guard[0] : 1'b1;
      data_valid_i = bp && (sb.size() > 1);
      start_i      = bp;
      data_i       = 32'hDEADBEEF;
      if (out_ready_i) void'(sb.pop_front());
      guard++;
      @(negedge clk);
    end
    data_valid_i = 1'b0;
    start_i      = 1'b0;
    out_ready_i  = 1'b1;
    if (guard >= 100) check("drain_timeout", 1, 0);
  endtask

  task automatic check_idle_after_drain();
    check("post_valid", out_valid_o, 0);
    check("post_last", out_last_o, 0);
    check("post_in_ready", in_ready_o, 1);
  endtask

  task automatic load_frame1();
    frm[0] = 32'h40AB0A3D; frm[1] = 32'h418A49BA; frm[2] = 32'h4158C8B4; frm[3] = 32'h41A0ED91;
    frm[4] = 32'h40B5FBE7; frm[5] = 32'h40FE872B; frm[6] = 32'h41035810; frm[7] = 32'h4166B020;
    frm[8] = 32'h4184126E; frm[9] = 32'h3E1CAC08;
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; data_valid_i = 1'b0; data_i = '0; out_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_max", out_max_o, 0);
    check("rst_idx", 32'(out_max_index_o), 0);
    check("rst_last", out_last_o, 0);
    check("rst_restart", restart_o, 0);
    reset_i = 1'b0;
    #1;
    check("in_ready_after_reset", in_ready_o, 1);
    @(negedge clk);

    // A word without start in IDLE is dropped.
    send_word(1'b0, 32'h7F000000);
    check("idle_drop_valid", out_valid_o, 0);
    check("idle_drop_max", out_max_o, 0);

    // Reference frame, no backpressure.
    load_frame1();
    send_frame(32'h41A0ED91, 3);
    drain(1'b0, 0);
    check_idle_after_drain();

    // All-negative frame with backpressure.
    frm[0] = 32'hBF800000; frm[1] = 32'hBF000000; frm[2] = 32'hC0000000;
    for (int i = 3; i < 10; i++) frm[i] = 32'hC0400000;
    send_frame(32'hBF000000, 1);
    drain(1'b1, 0);
    check_idle_after_drain();

    // Signed-zero tie keeps the earlier element.
    frm[0] = 32'h80000000; frm[1] = 32'h00000000;
    for (int i = 2; i < 10; i++) frm[i] = 32'hBF800000;
    send_frame(32'h80000000, 0);
    drain(1'b0, 0);
    check_idle_after_drain();

    // Restart on the 5th accept; only the new frame is replayed.
    send_word(1'b1, 32'h7F000000);
    for (int i = 0; i < 3; i++) send_word(1'b0, 32'h7F7FFFFF);
    load_frame1();
    push_frame(32'h41A0ED91, 3);
    send_word(1'b1, frm[0]);
    check("restart_pulse", restart_o, 1);
    send_word(1'b0, frm[1]);
    check("restart_single", restart_o, 0);
    for (int i = 2; i < 10; i++) begin
      check("restart_no_valid", out_valid_o, 0);
      send_word(1'b0, frm[i]);
    end
    check("restart_valid", out_valid_o, 1);
    drain(1'b0, 0);
    check_idle_after_drain();

    // Reset at rd_ptr = 4 mid-drain.
    send_frame(32'h41A0ED91, 3);
    drain(1'b0, 6);
    check("pre_reset_data", out_data_o, frm[4]);
    reset_i = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready_o, 0);
    reset_i = 1'b0;
    #1;
    check("reset_valid", out_valid_o, 0);
    check("reset_data", out_data_o, 0);
    check("reset_max", out_max_o, 0);
    check("reset_in_ready_idle", in_ready_o, 1);
    sb.delete();
    @(negedge clk);
    send_frame(32'h41A0ED91, 3);
    drain(1'b0, 0);
    check_idle_after_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
